// File: rtl/h264_pipe_pkg.sv
// Shared constants and helper functions for the encoder pipeline register chains.
// Used by both the 8-bit enable-register users and the parametrised chain.
package h264_pipe_pkg;

    localparam int DEFAULT_PIPE_WIDTH = 8;

    // popcount_f accepts at most this many stage-valid bits.
    localparam int MAX_POP_BITS = 64;

    function automatic int clog2_depth(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int popcount_f(input int n, input logic [MAX_POP_BITS-1:0] v);
        int count;
        count = 0;
        for (int i = 0; i < MAX_POP_BITS; i++) begin
            if ((i < n) && v[i]) begin
                count++;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One stage of the elastic register chain: a valid bit plus a data word.
// The data word only moves when a valid word is loaded, so bubbles never overwrite it.
module pipe_reg_stage
    import h264_pipe_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_PIPE_WIDTH,
    parameter int DATA_RST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ld,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_vld <= 1'b0;
        end else if (ld) begin
            r_vld <= src_valid;
        end
    end

    // Flush leaves data untouched; reset clears it only when DATA_RST is set.
    always_ff @(posedge clk) begin
        if (rst && (DATA_RST != 0)) begin
            r_dat <= '0;
        end else if (!rst && !flush && ld && src_valid) begin
            r_dat <= src_data;
        end
    end

    assign vld = r_vld;
    assign dat = r_dat;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage elastic pipeline register chain with valid/ready handshake,
// bubble collapsing and synchronous flush. Stage DEPTH-1 drives the output.
module pipe_reg_chain
    import h264_pipe_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_PIPE_WIDTH,
    parameter int DEPTH    = 2,
    parameter int DATA_RST = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2_depth(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = clog2_depth(DEPTH);

    logic [DEPTH-1:0]        w_vld;
    logic [DEPTH-1:0]        w_adv;
    logic [DEPTH-1:0]        w_ld;
    logic [DEPTH-1:0]        w_srcValid;
    logic [WIDTH-1:0]        w_dat     [DEPTH];
    logic [WIDTH-1:0]        w_srcData [DEPTH];
    logic [MAX_POP_BITS-1:0] w_vldExt;

    // Ready ripples from the output back to stage 0 with no register in between.
    always_comb begin
        w_adv = '0;
        w_ld  = '0;
        w_adv[DEPTH-1] = w_vld[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = w_vld[i] & (~w_vld[i+1] | w_adv[i+1]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_ld[i] = ~w_vld[i] | w_adv[i];
        end
    end

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_srcValid[g] = in_valid;
            assign w_srcData[g]  = in_data;
        end else begin : g_body
            assign w_srcValid[g] = w_vld[g-1];
            assign w_srcData[g]  = w_dat[g-1];
        end

        pipe_reg_stage #(
            .WIDTH    (WIDTH),
            .DATA_RST (DATA_RST)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .ld        (w_ld[g]),
            .src_valid (w_srcValid[g]),
            .src_data  (w_srcData[g]),
            .vld       (w_vld[g]),
            .dat       (w_dat[g])
        );
    end

    // Flush blanks both handshakes so nothing transfers in the flush cycle.
    assign in_ready  = w_ld[0] & ~flush;
    assign out_valid = w_vld[DEPTH-1] & ~flush;
    assign out_data  = w_dat[DEPTH-1];

    always_comb begin
        w_vldExt            = '0;
        w_vldExt[DEPTH-1:0] = w_vld;
        occupancy           = OCC_W'(popcount_f(DEPTH, w_vldExt));
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: three instances (DEPTH 3/4/2), directed vectors,
// expected words queued on acceptance and popped by a monitor on every output transfer.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;

    logic       aInValid, aInReady, aOutValid, aOutReady;
    logic [7:0] aInData, aOutData;
    logic [1:0] aOcc;

    logic       bInValid, bInReady, bOutValid, bOutReady;
    logic [7:0] bInData, bOutData;
    logic [2:0] bOcc;

    logic       cInValid, cInReady, cOutValid, cOutReady;
    logic [7:0] cInData, cOutData;
    logic [1:0] cOcc;

    logic [7:0] qA[$];
    logic [7:0] qB[$];
    logic [7:0] qC[$];

    int errors = 0;
    int checks = 0;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .DATA_RST(1)) u_dutA (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .occupancy(aOcc)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .DATA_RST(0)) u_dutB (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .occupancy(bOcc)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(2), .DATA_RST(0)) u_dutC (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData),
        .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData),
        .occupancy(cOcc)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [7:0] data);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got word 0x%0h, expected no word", name, data);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every output transfer must match the oldest accepted word.
    task automatic monitorOutputs();
        forever begin
            @(negedge clk);
            if (aOutValid && aOutReady) begin
                if (qA.size() == 0) reportUnexpected("A out word", aOutData);
                else checkOutput("A out word", aOutData, qA.pop_front());
            end
            if (bOutValid && bOutReady) begin
                if (qB.size() == 0) reportUnexpected("B out word", bOutData);
                else checkOutput("B out word", bOutData, qB.pop_front());
            end
            if (cOutValid && cOutReady) begin
                if (qC.size() == 0) reportUnexpected("C out word", cOutData);
                else checkOutput("C out word", cOutData, qC.pop_front());
            end
        end
    endtask

    // Offer one word for one cycle to instance 0/1/2 and queue it if accepted.
    task automatic applyStimulus(input int which, input logic [7:0] data, input logic expReady);
        case (which)
            0: begin aInValid = 1'b1; aInData = data; end
            1: begin bInValid = 1'b1; bInData = data; end
            default: begin cInValid = 1'b1; cInData = data; end
        endcase
        @(negedge clk);
        case (which)
            0: begin
                checkOutput("A in_ready", aInReady, expReady);
                if (aInReady) qA.push_back(data);
            end
            1: begin
                checkOutput("B in_ready", bInReady, expReady);
                if (bInReady) qB.push_back(data);
            end
            default: begin
                checkOutput("C in_ready", cInReady, expReady);
                if (cInReady) qC.push_back(data);
            end
        endcase
        tick();
        aInValid = 1'b0;
        bInValid = 1'b0;
        cInValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((qA.size() + qB.size() + qC.size()) != 0) && (n < 40)) begin
            tick();
            n++;
        end
        checkOutput("drain queues empty", qA.size() + qB.size() + qC.size(), 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        aInValid = 1'b0; aInData = '0; aOutReady = 1'b0;
        bInValid = 1'b0; bInData = '0; bOutReady = 1'b0;
        cInValid = 1'b0; cInData = '0; cOutReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset A out_valid", aOutValid, 0);
        checkOutput("reset A occupancy", aOcc, 0);
        checkOutput("reset A in_ready", aInReady, 1);
        checkOutput("reset A out_data", aOutData, 0);
        checkOutput("reset B occupancy", bOcc, 0);
        checkOutput("reset C in_ready", cInReady, 1);
        tick();
        fork
            monitorOutputs();
        join_none

        $display("[TB] streaming DEPTH=3");
        aOutReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            aInValid = 1'b1;
            aInData  = 8'(i + 1);
            @(negedge clk);
            checkOutput("A stream in_ready", aInReady, 1);
            checkOutput("A stream out_valid latency", aOutValid, (i >= 3) ? 1 : 0);
            if (aInReady) qA.push_back(aInData);
            tick();
        end
        aInValid = 1'b0;
        drain();

        $display("[TB] full stall DEPTH=3");
        aOutReady = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'hA0 + 8'(i), 1'b1);
        aInValid = 1'b1;
        aInData  = 8'hA3;
        repeat (2) begin
            @(negedge clk);
            checkOutput("A full in_ready", aInReady, 0);
            checkOutput("A full occupancy", aOcc, 3);
            checkOutput("A full out_data held", aOutData, 8'hA0);
            tick();
        end
        aOutReady = 1'b1;
        @(negedge clk);
        checkOutput("A full release in_ready", aInReady, 1);
        if (aInReady) qA.push_back(8'hA3);
        tick();
        aInValid = 1'b0;
        drain();

        $display("[TB] bubble collapse DEPTH=4");
        bOutReady = 1'b0;
        applyStimulus(1, 8'h55, 1'b1);
        tick();
        tick();
        applyStimulus(1, 8'h66, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        checkOutput("B bubble occupancy", bOcc, 2);
        checkOutput("B bubble out_valid", bOutValid, 1);
        checkOutput("B bubble out_data", bOutData, 8'h55);
        checkOutput("B bubble in_ready", bInReady, 1);
        tick();
        bOutReady = 1'b1;
        drain();

        $display("[TB] simultaneous in/out DEPTH=2");
        cOutReady = 1'b0;
        applyStimulus(2, 8'h11, 1'b1);
        applyStimulus(2, 8'h22, 1'b1);
        cInValid  = 1'b1;
        cInData   = 8'h33;
        cOutReady = 1'b1;
        @(negedge clk);
        checkOutput("C full occupancy before", cOcc, 2);
        checkOutput("C full in_ready", cInReady, 1);
        if (cInReady) qC.push_back(8'h33);
        tick();
        cInValid  = 1'b0;
        cOutReady = 1'b0;
        @(negedge clk);
        checkOutput("C occupancy after swap", cOcc, 2);
        checkOutput("C out_data after swap", cOutData, 8'h22);
        tick();
        cOutReady = 1'b1;
        drain();

        $display("[TB] flush DEPTH=3");
        aOutReady = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'hB0 + 8'(i), 1'b1);
        flush     = 1'b1;
        aInValid  = 1'b1;
        aInData   = 8'h77;
        aOutReady = 1'b1;
        @(negedge clk);
        checkOutput("A flush in_ready", aInReady, 0);
        checkOutput("A flush out_valid", aOutValid, 0);
        tick();
        flush    = 1'b0;
        aInValid = 1'b0;
        qA.delete();
        @(negedge clk);
        checkOutput("A post-flush occupancy", aOcc, 0);
        checkOutput("A post-flush out_valid", aOutValid, 0);
        repeat (4) tick();

        $display("[TB] reset mid-stream with flush DEPTH=3");
        aOutReady = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'hD0 + 8'(i), 1'b1);
        aInValid = 1'b1;
        aInData  = 8'hEE;
        rst      = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        checkOutput("A rst cycle in_ready", aInReady, 0);
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        aInValid = 1'b0;
        qA.delete();
        @(negedge clk);
        checkOutput("A post-rst out_valid", aOutValid, 0);
        checkOutput("A post-rst out_data", aOutData, 0);
        checkOutput("A post-rst occupancy", aOcc, 0);
        checkOutput("A post-rst in_ready", aInReady, 1);
        repeat (4) tick();

        checkOutput("final queues empty", qA.size() + qB.size() + qC.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
